// File: rtl/mux16_scan_serializer.sv
// mux16_scan_serializer: loads a parallel word over a valid/ready handshake,
// parks it on the mux16x1 data inputs and walks the mux select through every
// position, forwarding the returned bit as a valid/ready serial stream.
// Build option: define SER_MSB_FIRST_EN to emit the word MSB first
// (select counts down from WIDTH-1 to 0); default is LSB first.
module mux16_scan_serializer #(
    parameter int unsigned SEL_W = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] mux_in,
    output logic [SEL_W-1:0] mux_sel,
    input  logic             mux_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_data,
    output logic             ser_last,
    output logic             busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

`ifdef SER_MSB_FIRST_EN
    localparam logic [SEL_W-1:0] START_IDX = SEL_W'(WIDTH - 1);
    localparam logic [SEL_W-1:0] END_IDX   = SEL_W'(0);
`else
    localparam logic [SEL_W-1:0] START_IDX = SEL_W'(0);
    localparam logic [SEL_W-1:0] END_IDX   = SEL_W'(WIDTH - 1);
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mux_in_q, mux_in_d;
    logic [SEL_W-1:0] mux_sel_q, mux_sel_d;

    // State, held word and select registers; reset is asynchronous.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            mux_in_q  <= '0;
            mux_sel_q <= '0;
        end else begin
            state_q   <= state_d;
            mux_in_q  <= mux_in_d;
            mux_sel_q <= mux_sel_d;
        end
    end

    // Next-state and handshake decode; outputs depend only on registered state.
    always_comb begin
        state_d    = state_q;
        mux_in_d   = mux_in_q;
        mux_sel_d  = mux_sel_q;
        load_ready = 1'b0;
        ser_valid  = 1'b0;
        ser_last   = 1'b0;
        busy       = 1'b0;

        unique case (state_q)
            IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    mux_in_d  = load_data;
                    mux_sel_d = START_IDX;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                busy      = 1'b1;
                ser_valid = 1'b1;
                ser_last  = (mux_sel_q == END_IDX);
                if (ser_ready) begin
                    // Select only steps when not at the end index, so it never wraps.
                    if (ser_last) begin
                        state_d = IDLE;
                    end else begin
`ifdef SER_MSB_FIRST_EN
                        mux_sel_d = mux_sel_q - SEL_W'(1);
`else
                        mux_sel_d = mux_sel_q + SEL_W'(1);
`endif
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Data path is a straight pass-through of the mux result.
    assign ser_data = mux_out;
    assign mux_in   = mux_in_q;
    assign mux_sel  = mux_sel_q;

endmodule

// File: tb/tb_mux16_scan_serializer.sv
// Self-checking bench for mux16_scan_serializer with a behavioural 16:1 mux
// closing the loop from mux_in/mux_sel back to mux_out.
module tb_mux16_scan_serializer;

    localparam int unsigned SEL_W = 4;
    localparam int unsigned WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic [WIDTH-1:0] mux_in;
    logic [SEL_W-1:0] mux_sel;
    logic             mux_out;
    logic             ser_valid;
    logic             ser_ready;
    logic             ser_data;
    logic             ser_last;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    // Expected serial bits, pushed at load and popped on each beat transfer.
    bit exp_q[$];

    typedef struct {
        logic [15:0] word;
        logic [15:0] stream;  // bit k = k-th emitted bit
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    // mux16x1 behaviour
    assign mux_out = mux_in[mux_sel];

    mux16_scan_serializer #(
        .SEL_W(SEL_W),
        .WIDTH(WIDTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .mux_in     (mux_in),
        .mux_sel    (mux_sel),
        .mux_out    (mux_out),
        .ser_valid  (ser_valid),
        .ser_ready  (ser_ready),
        .ser_data   (ser_data),
        .ser_last   (ser_last),
        .busy       (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Select position expected while emitting the given beat.
    function automatic logic [3:0] sel_of(input int beat);
`ifdef SER_MSB_FIRST_EN
        return 4'(15 - beat);
`else
        return 4'(beat);
`endif
    endfunction

    // Emission order of a word as a stream (bit k = k-th bit out).
    function automatic logic [15:0] stream_of(input logic [15:0] word);
        logic [15:0] s;
        for (int k = 0; k < 16; k++) begin
`ifdef SER_MSB_FIRST_EN
            s[k] = word[15 - k];
`else
            s[k] = word[k];
`endif
        end
        return s;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ser_valid"},  32'(ser_valid),  32'd0);
        chk({tag, "_busy"},       32'(busy),       32'd0);
        chk({tag, "_load_ready"}, 32'(load_ready), 32'd1);
        chk({tag, "_ser_last"},   32'(ser_last),   32'd0);
        chk({tag, "_mux_sel"},    32'(mux_sel),    32'd0);
        chk({tag, "_mux_in"},     32'(mux_in),     32'd0);
    endtask

    // Called just after a negedge with the block idle. Loads one word and
    // drains it, with optional stalls at the first/last beat, random
    // ready, or a competing load held during SHIFT.
    task automatic run_word(input logic [15:0] word, input logic [15:0] stream,
                            input int stall_first, input int stall_last,
                            input bit rand_ready, input bit load_busy);
        int beat   = 0;
        int stalls = 0;
        int cyc    = 0;
        bit rdy;
        for (int k = 0; k < 16; k++) exp_q.push_back(stream[k]);
        load_valid = 1'b1;
        load_data  = word;
        #1;
        chk("idle_load_ready", 32'(load_ready), 32'd1);
        chk("idle_busy",       32'(busy),       32'd0);
        chk("idle_ser_valid",  32'(ser_valid),  32'd0);
        @(posedge clk);
        @(negedge clk);
        load_valid = load_busy;
        load_data  = load_busy ? 16'hffff : 16'($urandom);
        while (beat < 16 && cyc < 200) begin
            rdy = 1'b1;
            if (beat == 0 && stalls < stall_first) rdy = 1'b0;
            else if (beat == 15 && stalls < stall_last) rdy = 1'b0;
            else if (rand_ready) rdy = 1'($urandom_range(0, 1));
            ser_ready = rdy;
            #1;
            chk("beat_ser_valid",  32'(ser_valid),  32'd1);
            chk("beat_busy",       32'(busy),       32'd1);
            chk("beat_load_ready", 32'(load_ready), 32'd0);
            chk("beat_ser_data",   32'(ser_data),   32'(exp_q[0]));
            chk("beat_ser_last",   32'(ser_last),   32'(beat == 15));
            chk("beat_mux_sel",    32'(mux_sel),    32'(sel_of(beat)));
            chk("beat_mux_in",     32'(mux_in),     32'(word));
            @(posedge clk);
            if (rdy) begin
                void'(exp_q.pop_front());
                beat++;
                stalls = 0;
            end else begin
                stalls++;
            end
            cyc++;
            @(negedge clk);
        end
        chk("beats_done", 32'(beat), 32'd16);
        if (!rand_ready) chk("word_cycles", 32'(cyc), 32'(16 + stall_first + stall_last));
        // ser_ready high in IDLE must not disturb the held select or word.
        ser_ready = 1'b1;
        #1;
        chk("done_ser_valid",  32'(ser_valid),  32'd0);
        chk("done_busy",       32'(busy),       32'd0);
        chk("done_load_ready", 32'(load_ready), 32'd1);
        chk("done_ser_last",   32'(ser_last),   32'd0);
        chk("done_mux_sel",    32'(mux_sel),    32'(sel_of(15)));
        chk("done_mux_in",     32'(mux_in),     32'(word));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{word: 16'haf82, stream: `ifdef SER_MSB_FIRST_EN 16'h41f5 `else 16'haf82 `endif};
        vecs[1] = '{word: 16'h8001, stream: 16'h8001};
        vecs[2] = '{word: 16'h00ff, stream: `ifdef SER_MSB_FIRST_EN 16'hff00 `else 16'h00ff `endif};
        vecs[3] = '{word: 16'hffff, stream: 16'hffff};
        vecs[4] = '{word: 16'h0000, stream: 16'h0000};
        vecs[5] = '{word: 16'h5555, stream: `ifdef SER_MSB_FIRST_EN 16'haaaa `else 16'h5555 `endif};

        rst        = 1'b1;
        load_valid = 1'b0;
        load_data  = 16'h1234;
        ser_ready  = 1'b0;
        #3;
        chk_reset_outputs("por");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_reset_outputs("post_rst");
        @(negedge clk);

        // load_valid low: load_data must be ignored.
        repeat (2) @(negedge clk);
        #1;
        chk("no_load_busy",   32'(busy),   32'd0);
        chk("no_load_mux_in", 32'(mux_in), 32'd0);
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_word(vecs[i].word, vecs[i].stream, 0, 0, 1'b0, 1'b0);

        run_word(16'h8001, 16'h8001, 3, 2, 1'b0, 1'b0);

        run_word(16'h00ff, stream_of(16'h00ff), 0, 0, 1'b0, 1'b1);
        run_word(16'hffff, 16'hffff, 0, 0, 1'b0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            logic [15:0] w;
            w = 16'($urandom);
            run_word(w, stream_of(w), 0, 0, 1'b1, 1'b0);
        end

        // Asynchronous reset mid-word, between clock edges.
        load_valid = 1'b1;
        load_data  = 16'hbeef;
        @(posedge clk);
        @(negedge clk);
        load_valid = 1'b0;
        ser_ready  = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk_reset_outputs("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        #1;
        chk_reset_outputs("mid_rst_release");
        @(negedge clk);

        run_word(16'haf82, vecs[0].stream, 0, 0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux16_scan_serializer.md
Name: mux16_scan_serializer

Overview:
- Upstream sequencer for the team's 16:1 mux (mux16x1).
- Accepts a 16-bit word over a valid/ready load handshake and holds it on the mux data inputs.
- Steps the mux select through all 16 positions and forwards each selected bit as a valid/ready serial stream, flagging the last bit.
- Turns the combinational mux into a parallel-to-serial converter with backpressure.

Parameters:
- SEL_W, 4: select width driven to the mux.
- WIDTH, 16: data word width; must equal 2**SEL_W.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- load_valid  input  1  load_data is valid
- load_ready  output  1  block can accept a word
- load_data  input  WIDTH  parallel word to serialize
- mux_in  output  WIDTH  registered word, drives mux data inputs
- mux_sel  output  SEL_W  registered select, drives mux select
- mux_out  input  1  selected bit returned by the mux
- ser_valid  output  1  ser_data is valid
- ser_ready  input  1  downstream accepts ser_data
- ser_data  output  1  serial bit (combinational pass-through of mux_out)
- ser_last  output  1  current beat is the final bit of the word
- busy  output  1  a word is being serialized

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, mux_in=0, mux_sel=0.
  - load_ready=1, ser_valid=0, ser_last=0, busy=0.
  - Takes effect immediately, not on the next clock edge.
- States: IDLE and SHIFT.
- IDLE:
  - load_ready=1, ser_valid=0, busy=0.
  - On load_valid & load_ready at a clock edge:
    - mux_in <= load_data.
    - mux_sel <= start index (0 by default).
    - state <= SHIFT.
  - load_data is ignored when load_valid=0.
- SHIFT:
  - load_ready=0, busy=1, ser_valid=1, ser_data=mux_out.
  - ser_last=1 when mux_sel equals the end index (WIDTH-1 by default).
- Beat transfer (ser_valid & ser_ready at a clock edge):
  - Not last: mux_sel <= mux_sel+1.
  - Last: state <= IDLE; mux_sel holds its value; mux_in holds its value.
- Backpressure: while ser_ready=0, mux_sel and mux_in hold, and ser_valid stays 1. A bit is never skipped or repeated.
- Load while busy: load_valid is ignored in SHIFT. The upstream source must hold it until load_ready=1.
- Throughput and latency:
  - Minimum 17 cycles per word: 16 beats plus 1 IDLE cycle.
  - First bit valid 1 cycle after the load handshake.
- Select arithmetic:
  - SEL_W-bit unsigned; never wraps inside a word.
  - The increment is only performed when the select is not the end index.
- Reset mid-word: the remaining bits are discarded; the block returns to IDLE with outputs at their reset values.
- ser_ready asserted in IDLE: no effect.
- mux_out is sampled by downstream only on the handshake; the block itself adds no registering on the data path.

Optional Feature:
- Macro: SER_MSB_FIRST_EN.
- Defined:
  - Start index = WIDTH-1, end index = 0, step = mux_sel-1.
  - The word is emitted MSB first; ser_last is asserted when mux_sel==0.
- Undefined (default): LSB first, start 0, end WIDTH-1, step +1.
- Reset values are unchanged in both builds.

Test Plan:
- Bench connects mux16x1 between mux_in/mux_sel and mux_out in all scenarios.
- Reset:
  - Stimulus: assert rst mid-SHIFT asynchronously, between clock edges.
  - Response: ser_valid=0, busy=0, load_ready=1, mux_sel=0 and mux_in=0 immediately.
- Basic LSB-first word:
  - Stimulus: load 16'haf82, ser_ready=1 constantly.
  - Response: bits 0,1,0,0,0,0,0,1,1,1,1,1,0,1,0,1 on consecutive cycles; ser_last only on the 16th; load_ready returns to 1 the cycle after.
- Backpressure:
  - Stimulus: load 16'h8001; hold ser_ready=0 for 3 cycles at mux_sel=0 and for 2 cycles at mux_sel=15.
  - Response: ser_data=1 held at both stalls; exactly 16 beats transferred; mux_sel never advances while stalled.
- Load while busy:
  - Stimulus: load 16'h00ff, then assert load_valid with 16'hffff during SHIFT.
  - Response: load_ready=0; the first word is emitted intact (eight 1s then eight 0s); the second word is accepted only in IDLE, then emitted as sixteen 1s.
- SER_MSB_FIRST_EN build:
  - Stimulus: load 16'haf82.
  - Response: bits 1,0,1,0,1,1,1,1,1,0,0,0,0,0,1,0; ser_last when mux_sel==0.
